// File: rtl/gray_to_rgb565_stream_if.sv
// Valid/ready bus pair for the grayscale-to-RGB565 expander.
// The master modport is the surrounding system; the slave modport is the block.
interface gray_to_rgb565_stream_if;
  logic        sValid;
  logic        sReady;
  logic [31:0] sData;
  logic        sLast;
  logic        mValid;
  logic        mReady;
  logic [31:0] mData;
  logic        mLast;

  modport master (
    output sValid, sData, sLast, mReady,
    input  sReady, mValid, mData, mLast
  );

  modport slave (
    input  sValid, sData, sLast, mReady,
    output sReady, mValid, mData, mLast
  );
endinterface

// File: rtl/gray_to_rgb565_stream.sv
// Expands one word of four 8-bit gray pixels into two words of RGB565 pixel pairs.
// Define GRAY_RGB565_ROUND_EN for round-to-nearest with saturation instead of truncation.
module gray_to_rgb565_stream #(
  parameter bit FIRST_PIXEL_HIGH = 1'b0
) (
  input  logic                          clock,
  input  logic                          nReset,
  gray_to_rgb565_stream_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_t;

  function automatic logic [15:0] f_gray_to_565(input logic [7:0] g);
`ifdef GRAY_RGB565_ROUND_EN
    logic [8:0] w_sum_rb;
    logic [8:0] w_sum_g;
    logic [4:0] w_r5;
    logic [5:0] w_g6;
    w_sum_rb = {1'b0, g} + 9'd4;
    w_sum_g  = {1'b0, g} + 9'd2;
    // Bit 8 set means the shifted result overflowed the channel width.
    w_r5 = w_sum_rb[8] ? 5'd31 : w_sum_rb[7:3];
    w_g6 = w_sum_g[8]  ? 6'd63 : w_sum_g[7:2];
    return {w_r5, w_g6, w_r5};
`else
    return {g[7:3], g[7:2], g[7:3]};
`endif
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_mdata;
  logic [31:0] w_mdata_next;
  logic        r_mlast;
  logic        w_mlast_next;
  logic [31:0] r_hold;
  logic [31:0] w_hold_next;
  logic        r_hold_last;
  logic        w_hold_last_next;

  logic [7:0]  w_pix [4];
  logic [15:0] w_rgb [4];
  logic [31:0] w_word_lo;
  logic [31:0] w_word_hi;
  logic        w_load;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pix
      if (FIRST_PIXEL_HIGH) begin : g_high
        assign w_pix[gi] = bus.sData[31 - 8*gi -: 8];
      end else begin : g_low
        assign w_pix[gi] = bus.sData[8*gi +: 8];
      end
      assign w_rgb[gi] = f_gray_to_565(w_pix[gi]);
    end

    // The earlier pixel of each pair lands in the half that pixel 0 uses on input.
    if (FIRST_PIXEL_HIGH) begin : g_pack_high
      assign w_word_lo = {w_rgb[0], w_rgb[1]};
      assign w_word_hi = {w_rgb[2], w_rgb[3]};
    end else begin : g_pack_low
      assign w_word_lo = {w_rgb[1], w_rgb[0]};
      assign w_word_hi = {w_rgb[3], w_rgb[2]};
    end
  endgenerate

  assign bus.sReady = (r_state == ST_EMPTY) || ((r_state == ST_SECOND) && bus.mReady);
  assign bus.mValid = (r_state != ST_EMPTY);
  assign bus.mData  = r_mdata;
  assign bus.mLast  = r_mlast;
  assign w_load     = bus.sValid && bus.sReady;

  always_comb begin
    w_state_next     = r_state;
    w_mdata_next     = r_mdata;
    w_mlast_next     = r_mlast;
    w_hold_next      = r_hold;
    w_hold_last_next = r_hold_last;
    case (r_state)
      ST_FIRST: begin
        if (bus.mReady) begin
          w_state_next = ST_SECOND;
          w_mdata_next = r_hold;
          w_mlast_next = r_hold_last;
        end
      end
      ST_SECOND: begin
        if (bus.mReady && !bus.sValid) begin
          w_state_next = ST_EMPTY;
        end
      end
      default: ;
    endcase
    // Loading is shared by EMPTY and the no-bubble SECOND->FIRST path.
    if (w_load) begin
      w_state_next     = ST_FIRST;
      w_mdata_next     = w_word_lo;
      w_mlast_next     = 1'b0;
      w_hold_next      = w_word_hi;
      w_hold_last_next = bus.sLast;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state     <= ST_EMPTY;
      r_mdata     <= 32'd0;
      r_mlast     <= 1'b0;
      r_hold      <= 32'd0;
      r_hold_last <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mdata     <= w_mdata_next;
      r_mlast     <= w_mlast_next;
      r_hold      <= w_hold_next;
      r_hold_last <= w_hold_last_next;
    end
  end

endmodule

// File: tb/tb_gray_to_rgb565_stream.sv
// Directed bench for gray_to_rgb565_stream: vector table plus stall, burst and reset sequences.
// Expected values follow GRAY_RGB565_ROUND_EN when it is defined for the build.
module tb_gray_to_rgb565_stream;

  logic clock;
  logic nReset;
  int   total;
  int   bad;

  gray_to_rgb565_stream_if bus0 ();
  gray_to_rgb565_stream_if bus1 ();

  gray_to_rgb565_stream #(.FIRST_PIXEL_HIGH(1'b0)) dut0 (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus0.slave)
  );

  gray_to_rgb565_stream #(.FIRST_PIXEL_HIGH(1'b1)) dut1 (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] sdata;
    logic        slast;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with mReady=1; returns at a negedge with the block empty.
  task automatic send_vec(input int idx, input string tag);
    int n;
    n = 0;
    while (!bus0.sReady && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_sready"}, {31'd0, bus0.sReady}, 32'd1);
    bus0.sValid = 1'b1;
    bus0.sData  = vecs[idx].sdata;
    bus0.sLast  = vecs[idx].slast;
    @(posedge clock);
    #1;
    bus0.sValid = 1'b0;
    bus0.sData  = 32'hDEADBEEF;
    bus0.sLast  = 1'b1;
    @(negedge clock);
    chk({tag, "_mvalid0"}, {31'd0, bus0.mValid}, 32'd1);
    chk({tag, "_w0"}, bus0.mData, vecs[idx].exp_w0);
    chk({tag, "_last0"}, {31'd0, bus0.mLast}, 32'd0);
    @(negedge clock);
    chk({tag, "_mvalid1"}, {31'd0, bus0.mValid}, 32'd1);
    chk({tag, "_w1"}, bus0.mData, vecs[idx].exp_w1);
    chk({tag, "_last1"}, {31'd0, bus0.mLast}, {31'd0, vecs[idx].slast});
    @(negedge clock);
    chk({tag, "_idle"}, {31'd0, bus0.mValid}, 32'd0);
    bus0.sLast = 1'b0;
    $display("xfer %s in=%h out=%h,%h", tag, vecs[idx].sdata, vecs[idx].exp_w0, vecs[idx].exp_w1);
  endtask

  initial begin
    total = 0;
    bad   = 0;

`ifdef GRAY_RGB565_ROUND_EN
    vecs[0] = '{32'h7F80FF00, 1'b0, 32'hFFFF0000, 32'h84108410};
    vecs[1] = '{32'h030000FE, 1'b1, 32'h0000FFFF, 32'h00200000};
    vecs[2] = '{32'h12345678, 1'b0, 32'h5ACB7BCF, 32'h10A239A7};
`else
    vecs[0] = '{32'h7F80FF00, 1'b0, 32'hFFFF0000, 32'h7BEF8410};
    vecs[1] = '{32'h030000FE, 1'b1, 32'h0000FFFF, 32'h00000000};
    vecs[2] = '{32'h12345678, 1'b0, 32'h52AA7BCF, 32'h108231A6};
`endif
    vecs[3] = '{32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};

    nReset      = 1'b0;
    bus0.sValid = 1'b0;
    bus0.sData  = 32'd0;
    bus0.sLast  = 1'b0;
    bus0.mReady = 1'b1;
    bus1.sValid = 1'b0;
    bus1.sData  = 32'd0;
    bus1.sLast  = 1'b0;
    bus1.mReady = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_mvalid", {31'd0, bus0.mValid}, 32'd0);
    chk("rst_mdata", bus0.mData, 32'd0);
    chk("rst_mlast", {31'd0, bus0.mLast}, 32'd0);
    chk("rst_sready", {31'd0, bus0.sReady}, 32'd1);
    nReset = 1'b1;
    @(negedge clock);

    // Table-driven single words
    for (int i = 0; i < 4; i++) begin
      send_vec(i, $sformatf("vec%0d", i));
    end

    // Back-to-back burst of four words, last word flagged
    for (int c = 0; c <= 9; c++) begin
      if (c <= 8) begin
        chk($sformatf("burst_sready_c%0d", c), {31'd0, bus0.sReady}, {31'd0, (c % 2) == 0});
      end
      if (c >= 1 && c <= 8) begin
        chk($sformatf("burst_mvalid_c%0d", c), {31'd0, bus0.mValid}, 32'd1);
        chk($sformatf("burst_data_c%0d", c), bus0.mData,
            ((c - 1) % 2 == 0) ? vecs[(c - 1) / 2].exp_w0 : vecs[(c - 1) / 2].exp_w1);
        chk($sformatf("burst_last_c%0d", c), {31'd0, bus0.mLast}, {31'd0, c == 8});
        $display("xfer burst out%0d=%h last=%0d", c - 1, bus0.mData, bus0.mLast);
      end
      if (c == 9) begin
        chk("burst_idle", {31'd0, bus0.mValid}, 32'd0);
      end
      bus0.sValid = (c < 8) && ((c % 2) == 0);
      bus0.sData  = vecs[(c / 2) % 4].sdata;
      bus0.sLast  = (c / 2) == 3;
      @(posedge clock);
      #1;
      bus0.sValid = 1'b0;
      @(negedge clock);
    end
    bus0.sLast = 1'b0;

    // Output stalls in FIRST and in SECOND
    bus0.mReady = 1'b0;
    bus0.sValid = 1'b1;
    bus0.sData  = vecs[1].sdata;
    bus0.sLast  = 1'b1;
    @(posedge clock);
    #1;
    bus0.sValid = 1'b0;
    bus0.sLast  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      bus0.sValid = 1'b1;
      chk($sformatf("stall1_mvalid%0d", k), {31'd0, bus0.mValid}, 32'd1);
      chk($sformatf("stall1_data%0d", k), bus0.mData, vecs[1].exp_w0);
      chk($sformatf("stall1_last%0d", k), {31'd0, bus0.mLast}, 32'd0);
      chk($sformatf("stall1_sready%0d", k), {31'd0, bus0.sReady}, 32'd0);
    end
    bus0.sValid = 1'b0;
    bus0.mReady = 1'b1;
    @(posedge clock);
    #1;
    bus0.mReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("stall2_mvalid%0d", k), {31'd0, bus0.mValid}, 32'd1);
      chk($sformatf("stall2_data%0d", k), bus0.mData, vecs[1].exp_w1);
      chk($sformatf("stall2_last%0d", k), {31'd0, bus0.mLast}, 32'd1);
      chk($sformatf("stall2_sready%0d", k), {31'd0, bus0.sReady}, 32'd0);
    end
    bus0.mReady = 1'b1;
    @(negedge clock);
    chk("stall_idle", {31'd0, bus0.mValid}, 32'd0);
    $display("xfer stall word %h done", vecs[1].sdata);

    // Mirrored pixel order on dut1
    bus1.sValid = 1'b1;
    bus1.sData  = 32'h00FF807F;
    @(posedge clock);
    #1;
    bus1.sValid = 1'b0;
    @(negedge clock);
    chk("fph_w0", bus1.mData, 32'h0000FFFF);
    @(negedge clock);
`ifdef GRAY_RGB565_ROUND_EN
    chk("fph_w1", bus1.mData, 32'h84108410);
`else
    chk("fph_w1", bus1.mData, 32'h84107BEF);
`endif
    @(negedge clock);
    chk("fph_idle", {31'd0, bus1.mValid}, 32'd0);
    $display("xfer fph in=00ff807f");

    // Asynchronous reset while a pair is in flight
    bus0.sValid = 1'b1;
    bus0.sData  = vecs[3].sdata;
    bus0.sLast  = 1'b1;
    @(posedge clock);
    #1;
    bus0.sValid = 1'b0;
    bus0.sLast  = 1'b0;
    #2;
    nReset = 1'b0;
    #1;
    chk("arst_mvalid", {31'd0, bus0.mValid}, 32'd0);
    chk("arst_mdata", bus0.mData, 32'd0);
    chk("arst_mlast", {31'd0, bus0.mLast}, 32'd0);
    @(negedge clock);
    nReset = 1'b1;
    @(negedge clock);
    send_vec(2, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
